c17_resp_analyzer: RTL and testbench

- Response-side BIST block for the c17 lab. The exhaustive stimulus side applies the 32 input vectors {N7,N6,N3,N2,N1} = 0..31 in ascending order.
- This block is the other end: it samples the c17 outputs {N23,N22} once per vector and compacts them into a MISR signature.
- After NUM_VEC responses it compares the signature against a golden value and reports pass/fail.

---
 rtl/c17_bist_pkg.sv | 29 ++
 rtl/c17_misr.sv | 45 ++++
 rtl/c17_resp_analyzer.sv | 145 ++++++++++++++
 tb/tb_c17_resp_analyzer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST response side.
// Holds the FSM state encoding, the default MISR polynomial and seed, the vector
// count, and a gate-level c17 reference used by the optional fail-capture logic
// (enabled with C17_FAIL_CAPTURE_EN).
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } c17_state_e;

  localparam logic [15:0] C17_DEF_POLY = 16'h1021;
  localparam logic [15:0] C17_DEF_SEED = 16'hFFFF;
  localparam int          C17_NUM_VEC  = 32;

  // c17 netlist: idx = {N7,N6,N3,N2,N1}, result = {N23,N22}
  function automatic logic [1:0] c17_golden(input logic [4:0] idx);
    logic n1, n2, n3, n6, n7;
    logic g10, g11, g16, g19;
    {n7, n6, n3, n2, n1} = idx;
    g10 = ~(n1 & n3);
    g11 = ~(n3 & n6);
    g16 = ~(n2 & g11);
    g19 = ~(g11 & n7);
    return {~(g16 & g19), ~(g10 & g16)};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register for the 2-bit c17 response.
// load has priority over en; sig_next is the value one compaction step ahead,
// exported so the owner can judge the final signature in the same edge it lands.
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter int          W    = 16,
  parameter logic [W-1:0] POLY = W'(C17_DEF_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [1:0]   din,
  output logic [W-1:0] sig,
  output logic [W-1:0] sig_next
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  // One Galois-style step: shift left, fold POLY on carry-out, xor in response
  always_comb begin
    sig_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ {{(W-2){1'b0}}, din};
    sig_d    = sig_q;
    if (load) begin
      sig_d = load_val;
    end else if (en) begin
      sig_d = sig_next;
    end
  end

  // Signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c17_resp_analyzer.sv
// c17 response analyzer: compacts NUM_VEC {N23,N22} responses into a MISR and
// compares the result against GOLDEN_SIG.
// Handshake: a response is consumed on every cycle resp_valid=1 while the run is
// in COMPACT and start=0; there is no backpressure. start in any state restarts.
// Optional C17_FAIL_CAPTURE_EN: per-vector check against a c17 reference, with
// fail_seen / first_fail_idx outputs and pass additionally gated on no mismatch.
module c17_resp_analyzer
  import c17_bist_pkg::*;
#(
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] POLY       = MISR_W'(C17_DEF_POLY),
  parameter logic [MISR_W-1:0] SEED       = MISR_W'(C17_DEF_SEED),
  parameter int                NUM_VEC    = C17_NUM_VEC,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [1:0]        resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [5:0]        vec_cnt
`ifdef C17_FAIL_CAPTURE_EN
  ,
  output logic              fail_seen,
  output logic [4:0]        first_fail_idx
`endif
);

  c17_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [5:0]  vec_cnt_q, vec_cnt_d;
  logic        accept;
  logic        last;
  logic        fail_any;
  logic [MISR_W-1:0] sig_next;

  assign accept = (state_q == COMPACT) && resp_valid && !start;
  assign last   = accept && (vec_cnt_q == 6'(NUM_VEC - 1));

  c17_misr #(
    .W    (MISR_W),
    .POLY (POLY)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .load_val (SEED),
    .en       (accept),
    .din      (resp),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef C17_FAIL_CAPTURE_EN
  logic       fail_seen_q, fail_seen_d;
  logic [4:0] ffi_q, ffi_d;
  logic       mismatch;

  assign mismatch = accept && (resp != c17_golden(vec_cnt_q[4:0]));
  assign fail_any = fail_seen_q || mismatch;

  // Sticky first-failure capture, cleared on start
  always_comb begin
    fail_seen_d = fail_seen_q;
    ffi_d       = ffi_q;
    if (start) begin
      fail_seen_d = 1'b0;
      ffi_d       = '0;
    end else if (mismatch && !fail_seen_q) begin
      fail_seen_d = 1'b1;
      ffi_d       = vec_cnt_q[4:0];
    end
  end

  // Fail-capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen_q <= 1'b0;
      ffi_q       <= '0;
    end else begin
      fail_seen_q <= fail_seen_d;
      ffi_q       <= ffi_d;
    end
  end

  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = ffi_q;
`else
  assign fail_any = 1'b0;
`endif

  // Next-state and registered-output logic of the run FSM
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    vec_cnt_d = vec_cnt_q;
    if (start) begin
      state_d   = COMPACT;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      vec_cnt_d = '0;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + 6'd1;
      if (last) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // judged on the signature this same edge loads
        pass_d  = (sig_next == GOLDEN_SIG) && !fail_any;
      end
    end
  end

  // Run FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_c17_resp_analyzer.sv
// Bench for c17_resp_analyzer. Three instances with different SEED / NUM_VEC /
// GOLDEN_SIG. Stimulus pushes the expected run result into exp_q; a monitor pops
// and compares on each rising edge of done. Define C17_FAIL_CAPTURE_EN to
// exercise the fail-capture outputs as well.
module tb_c17_resp_analyzer;

`ifdef C17_FAIL_CAPTURE_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] sig;
    logic        chk_sig;
    logic        pass;
    logic [5:0]  cnt;
    logic        fs;
    logic [4:0]  ffi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [3];
  logic        valid_v [3];
  logic [1:0]  resp_v  [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        pass_w  [3];
  logic [15:0] sig_w   [3];
  logic [5:0]  cnt_w   [3];
`ifdef C17_FAIL_CAPTURE_EN
  logic        fs_w    [3];
  logic [4:0]  ffi_w   [3];
`endif

  exp_t        exp_q[$];
  logic [1:0]  rv [32];
  logic        done_prev [3];
  int          total = 0;
  int          bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  c17_resp_analyzer #(.SEED(16'h0000), .NUM_VEC(32), .GOLDEN_SIG(16'h0000)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .resp_valid(valid_v[0]), .resp(resp_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0]), .vec_cnt(cnt_w[0])
`ifdef C17_FAIL_CAPTURE_EN
    , .fail_seen(fs_w[0]), .first_fail_idx(ffi_w[0])
`endif
  );

  c17_resp_analyzer #(.SEED(16'h0000), .NUM_VEC(2), .GOLDEN_SIG(16'h0002)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .resp_valid(valid_v[1]), .resp(resp_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1]), .vec_cnt(cnt_w[1])
`ifdef C17_FAIL_CAPTURE_EN
    , .fail_seen(fs_w[1]), .first_fail_idx(ffi_w[1])
`endif
  );

  c17_resp_analyzer #(.SEED(16'h8000), .NUM_VEC(1), .GOLDEN_SIG(16'h1021)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .resp_valid(valid_v[2]), .resp(resp_v[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2]), .vec_cnt(cnt_w[2])
`ifdef C17_FAIL_CAPTURE_EN
    , .fail_seen(fs_w[2]), .first_fail_idx(ffi_w[2])
`endif
  );

  // ---------------- helpers ----------------
  // c17 reference in sum-of-products form; idx = {N7,N6,N3,N2,N1}
  function automatic logic [1:0] c17_ref(input logic [4:0] idx);
    logic n1, n2, n3, n6, n7, b;
    n1 = idx[0]; n2 = idx[1]; n3 = idx[2]; n6 = idx[3]; n7 = idx[4];
    b  = ~(n3 & n6);
    return {b & (n2 | n7), (n1 & n3) | (n2 & b)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic do_start(input int k);
    start_v[k] = 1'b1;
    valid_v[k] = 1'b0;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [1:0] r, input logic v);
    resp_v[k]  = r;
    valid_v[k] = v;
    @(posedge clk); #1;
    valid_v[k] = 1'b0;
  endtask

  // Sends rv[0..n-1] back to back, checking count and done timing per step
  task automatic run_resp(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      chk("done_early", done_w[k], 1'b0);
      send(k, rv[i], 1'b1);
      chk("vec_cnt_step", cnt_w[k], i + 1);
    end
    chk("done_after_last", done_w[k], 1'b1);
    chk("busy_after_last", busy_w[k], 1'b0);
  endtask

  // Expected run outcome from rv[0..n-1]
  task automatic push(input int k, input int n, input logic [15:0] sig,
                      input bit chk_sig, input logic [15:0] gold);
    exp_t e;
    bit   mism;
    mism  = 1'b0;
    e     = '0;
    for (int i = 0; i < n; i++) begin
      if (!mism && rv[i] != c17_ref(5'(i))) begin
        mism  = 1'b1;
        e.ffi = 5'(i);
      end
    end
    e.k       = 2'(k);
    e.sig     = sig;
    e.chk_sig = chk_sig;
    e.cnt     = 6'(n);
    e.fs      = mism;
    e.pass    = chk_sig && (sig == gold) && !(FC && mism);
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k] === 1'b1 && done_prev[k] !== 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done: inst %0d raised done with no expected run", k);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_inst", k, e.k);
          if (e.chk_sig) chk("sb_signature", sig_w[k], e.sig);
          chk("sb_pass", pass_w[k], e.pass);
          chk("sb_vec_cnt", cnt_w[k], e.cnt);
`ifdef C17_FAIL_CAPTURE_EN
          chk("sb_fail_seen", fs_w[k], e.fs);
          if (e.fs) chk("sb_first_fail_idx", ffi_w[k], e.ffi);
`endif
        end
      end
      done_prev[k] = done_w[k];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; valid_v[k] = 1'b0; resp_v[k] = 2'b00; done_prev[k] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", busy_w[k], 1'b0);
      chk("rst_done", done_w[k], 1'b0);
      chk("rst_pass", pass_w[k], 1'b0);
      chk("rst_sig", sig_w[k], 16'h0000);
      chk("rst_cnt", cnt_w[k], 6'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // gaps in resp_valid: only valid cycles advance
    do_start(0);
    chk("start_busy", busy_w[0], 1'b1);
    chk("start_sig", sig_w[0], 16'h0000);
    send(0, 2'b01, 1'b1);
    chk("gap_sig1", sig_w[0], 16'h0001);
    send(0, 2'b11, 1'b0);
    send(0, 2'b11, 1'b0);
    chk("gap_sig_hold", sig_w[0], 16'h0001);
    chk("gap_cnt_hold", cnt_w[0], 6'd1);
    send(0, 2'b01, 1'b1);
    chk("gap_sig2", sig_w[0], 16'h0003);
    chk("gap_cnt2", cnt_w[0], 6'd2);

    // up to vec_cnt=10, then restart with a concurrent (discarded) response
    for (int i = 0; i < 8; i++) send(0, 2'b01, 1'b1);
    chk("pre_restart_sig", sig_w[0], 16'h03FF);
    chk("pre_restart_cnt", cnt_w[0], 6'd10);
    start_v[0] = 1'b1; valid_v[0] = 1'b1; resp_v[0] = 2'b11;
    @(posedge clk); #1;
    start_v[0] = 1'b0; valid_v[0] = 1'b0;
    chk("restart_cnt", cnt_w[0], 6'd0);
    chk("restart_sig", sig_w[0], 16'h0000);
    chk("restart_done", done_w[0], 1'b0);
    chk("restart_busy", busy_w[0], 1'b1);
`ifdef C17_FAIL_CAPTURE_EN
    chk("restart_fail_seen", fs_w[0], 1'b0);
`endif

    // 32 all-zero responses: signature stays 0
    for (int i = 0; i < 32; i++) rv[i] = 2'b00;
    push(0, 32, 16'h0000, 1'b1, 16'h0000);
    run_resp(0, 32);

    // responses in DONE are ignored
    send(0, 2'b11, 1'b1);
    send(0, 2'b10, 1'b1);
    chk("done_sig_frozen", sig_w[0], 16'h0000);
    chk("done_cnt_frozen", cnt_w[0], 6'd32);
    chk("done_sticky", done_w[0], 1'b1);

    // NUM_VEC=2: 01,00 -> 0x0001, 0x0002 (matches golden)
    rv[0] = 2'b01; rv[1] = 2'b00;
    push(1, 2, 16'h0002, 1'b1, 16'h0002);
    do_start(1);
    send(1, 2'b01, 1'b1);
    chk("b_sig1", sig_w[1], 16'h0001);
    chk("b_done_early", done_w[1], 1'b0);
    send(1, 2'b00, 1'b1);
    chk("b_sig2", sig_w[1], 16'h0002);
    chk("b_done", done_w[1], 1'b1);

    // NUM_VEC=2 restart from DONE: 01,01 -> 0x0003, no match
    rv[0] = 2'b01; rv[1] = 2'b01;
    push(1, 2, 16'h0003, 1'b1, 16'h0002);
    do_start(1);
    chk("b_restart_done", done_w[1], 1'b0);
    run_resp(1, 2);

    // NUM_VEC=2: true c17 responses (00,00) -> 0x0000, no signature match
    rv[0] = 2'b00; rv[1] = 2'b00;
    push(1, 2, 16'h0000, 1'b1, 16'h0002);
    do_start(1);
    run_resp(1, 2);

    // SEED=0x8000, resp 00 -> 0x1021
    rv[0] = 2'b00;
    push(2, 1, 16'h1021, 1'b1, 16'h1021);
    do_start(2);
    run_resp(2, 1);

`ifdef C17_FAIL_CAPTURE_EN
    // true responses except index 5 inverted
    for (int i = 0; i < 32; i++) rv[i] = c17_ref(5'(i));
    rv[5] = ~c17_ref(5'd5);
    push(0, 32, 16'h0000, 1'b0, 16'h0000);
    do_start(0);
    run_resp(0, 32);
    chk("fc_first_fail_idx", ffi_w[0], 5'd5);
`endif

    // asynchronous reset in the middle of a run
    do_start(0);
    for (int i = 0; i < 3; i++) send(0, 2'b01, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_w[0], 1'b0);
    chk("arst_done", done_w[0], 1'b0);
    chk("arst_pass", pass_w[0], 1'b0);
    chk("arst_sig", sig_w[0], 16'h0000);
    chk("arst_cnt", cnt_w[0], 6'd0);
    @(negedge clk); rst_n = 1'b1;

    repeat (5) @(posedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
